// File: rtl/rename_reg_file.sv
// Architectural register file with per-register ROB rename tags.
// Reads are combinational with a same-cycle commit bypass; writes land on the next clock edge.
module rename_reg_file #(
    parameter int REG_NUM = 32,
    parameter int REG_W   = 5,
    parameter int ROB_W   = 4,
    parameter int XLEN    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             jump_wrong,
    input  logic             rn_en,
    input  logic [REG_W-1:0] rn_rd,
    input  logic [ROB_W-1:0] rn_tag,
    input  logic             cm_en,
    input  logic [REG_W-1:0] cm_rd,
    input  logic [ROB_W-1:0] cm_tag,
    input  logic [XLEN-1:0]  cm_val,
    input  logic [REG_W-1:0] rs1_addr,
    output logic [XLEN-1:0]  rs1_val,
    output logic             rs1_busy,
    output logic [ROB_W-1:0] rs1_tag,
    input  logic [REG_W-1:0] rs2_addr,
    output logic [XLEN-1:0]  rs2_val,
    output logic             rs2_busy,
    output logic [ROB_W-1:0] rs2_tag
);

    logic [XLEN-1:0]    val_q [REG_NUM];
    logic [ROB_W-1:0]   tag_q [REG_NUM];
    logic [REG_NUM-1:0] busy_q;

    logic cm_ok;
    logic rn_ok;

    assign cm_ok = rdy && cm_en && (cm_rd != '0);
    assign rn_ok = rdy && rn_en && (rn_rd != '0) && !jump_wrong;

    // Assignment order matters: a rename overrides the commit's busy clear on the
    // same register, and a flush overrides both.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            if (cm_ok) begin
                val_q[cm_rd] <= cm_val;
                if (busy_q[cm_rd] && (tag_q[cm_rd] == cm_tag))
                    busy_q[cm_rd] <= 1'b0;
            end
            if (rn_ok) begin
                busy_q[rn_rd] <= 1'b1;
                tag_q[rn_rd]  <= rn_tag;
            end
            if (jump_wrong)
                busy_q <= '0;
        end
    end

    // Returns {busy, tag, val}; a commit retiring the owed tag is forwarded at once.
    function automatic logic [XLEN+ROB_W:0] rd_port(input logic [REG_W-1:0] a);
        logic hit;
        hit     = 1'b0;
        rd_port = '0;
        if (a != '0) begin
            hit = rdy && cm_en && busy_q[a] && (cm_rd == a) && (cm_tag == tag_q[a]);
            if (hit)
                rd_port = {1'b0, {ROB_W{1'b0}}, cm_val};
            else
                rd_port = {busy_q[a], tag_q[a], val_q[a]};
        end
    endfunction

    always_comb begin
        {rs1_busy, rs1_tag, rs1_val} = rd_port(rs1_addr);
        {rs2_busy, rs2_tag, rs2_val} = rd_port(rs2_addr);
    end

endmodule

// File: tb/tb_rename_reg_file.sv
// Table-driven bench for rename_reg_file: each record is one cycle of stimulus plus the
// read-port results expected in that cycle; expectations go through a scoreboard queue.
module tb_rename_reg_file;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        jump_wrong;
    logic        rn_en;
    logic [4:0]  rn_rd;
    logic [3:0]  rn_tag;
    logic        cm_en;
    logic [4:0]  cm_rd;
    logic [3:0]  cm_tag;
    logic [31:0] cm_val;
    logic [4:0]  rs1_addr;
    logic [31:0] rs1_val;
    logic        rs1_busy;
    logic [3:0]  rs1_tag;
    logic [4:0]  rs2_addr;
    logic [31:0] rs2_val;
    logic        rs2_busy;
    logic [3:0]  rs2_tag;

    rename_reg_file dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .jump_wrong (jump_wrong),
        .rn_en      (rn_en),
        .rn_rd      (rn_rd),
        .rn_tag     (rn_tag),
        .cm_en      (cm_en),
        .cm_rd      (cm_rd),
        .cm_tag     (cm_tag),
        .cm_val     (cm_val),
        .rs1_addr   (rs1_addr),
        .rs1_val    (rs1_val),
        .rs1_busy   (rs1_busy),
        .rs1_tag    (rs1_tag),
        .rs2_addr   (rs2_addr),
        .rs2_val    (rs2_val),
        .rs2_busy   (rs2_busy),
        .rs2_tag    (rs2_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mode: 0 = no check, 1 = busy+val, 2 = busy+tag+val
    typedef struct {
        bit        rst, rdy, jw, rn_en, cm_en;
        bit [4:0]  rn_rd, cm_rd, a1, a2;
        bit [3:0]  rn_tag, cm_tag, t1, t2;
        bit [31:0] cm_val, v1, v2;
        int        m1, m2;
        bit        b1, b2;
    } vec_t;

    typedef struct {
        int        idx;
        int        port;
        int        mode;
        bit        busy;
        bit [3:0]  tag;
        bit [31:0] val;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input bit r, input bit rd, input bit jw,
                       input bit rne, input int rnr, input int rnt,
                       input bit cme, input int cmr, input int cmt, input logic [31:0] cmv,
                       input int a1, input int m1, input bit b1, input int t1, input logic [31:0] v1,
                       input int a2, input int m2, input bit b2, input int t2, input logic [31:0] v2);
        vec_t v;
        v.rst = r;  v.rdy = rd; v.jw = jw;
        v.rn_en = rne; v.rn_rd = 5'(rnr); v.rn_tag = 4'(rnt);
        v.cm_en = cme; v.cm_rd = 5'(cmr); v.cm_tag = 4'(cmt); v.cm_val = cmv;
        v.a1 = 5'(a1); v.m1 = m1; v.b1 = b1; v.t1 = 4'(t1); v.v1 = v1;
        v.a2 = 5'(a2); v.m2 = m2; v.b2 = b2; v.t2 = 4'(t2); v.v2 = v2;
        vecs.push_back(v);
    endtask

    task automatic check(input exp_t e, input bit busy, input logic [3:0] tag, input logic [31:0] val);
        bit bad;
        if (e.mode == 0) return;
        n_vec++;
        bad = (busy !== e.busy) || (val !== e.val) || ((e.mode == 2) && (tag !== e.tag));
        if (bad) begin
            n_err++;
            $display("FAIL vec%0d rs%0d: got busy=%0b tag=%0d val=%h, want busy=%0b tag=%0d val=%h",
                     e.idx, e.port, busy, tag, val, e.busy, e.tag, e.val);
        end
    endtask

    initial begin
        exp_t e;
        rst = 1'b0; rdy = 1'b1; jump_wrong = 1'b0;
        rn_en = 1'b0; rn_rd = '0; rn_tag = '0;
        cm_en = 1'b0; cm_rd = '0; cm_tag = '0; cm_val = '0;
        rs1_addr = '0; rs2_addr = '0;

        //  rst rdy jw | rn_en rd tag | cm_en rd tag val | rs1 m b t val | rs2 m b t val
        // reset cycle, with rename/commit that must be ignored
        add(0,1,0, 1,5,7,  1,6,0,32'hAA,        0,0,0,0,0,          0,0,0,0,0);
        for (int r = 1; r < 32; r += 2)
            add(1,1,0, 0,0,0, 0,0,0,0, r,2,0,0,0, (r == 31) ? 0 : r + 1,2,0,0,0);
        // rename / bypass / commit on x5
        add(1,1,0, 1,5,3,  0,0,0,0,             5,2,0,0,0,          0,2,0,0,0);
        add(1,1,0, 0,0,0,  0,0,0,0,             5,2,1,3,0,          0,2,0,0,0);
        add(1,1,0, 0,0,0,  1,5,3,32'hDEADBEEF,  5,2,0,0,32'hDEADBEEF, 6,2,0,0,0);
        add(1,1,0, 0,0,0,  0,0,0,0,             5,1,0,0,32'hDEADBEEF, 0,2,0,0,0);
        // two renames of x7, stale commit keeps the newer one
        add(1,1,0, 1,7,2,  0,0,0,0,             7,2,0,0,0,          5,1,0,0,32'hDEADBEEF);
        add(1,1,0, 1,7,9,  0,0,0,0,             7,2,1,2,0,          0,2,0,0,0);
        add(1,1,0, 0,0,0,  1,7,2,32'h11,        7,2,1,9,0,          0,2,0,0,0);
        add(1,1,0, 0,0,0,  0,0,0,0,             7,2,1,9,32'h11,     0,2,0,0,0);
        add(1,1,0, 0,0,0,  1,7,9,32'h22,        7,2,0,0,32'h22,     0,2,0,0,0);
        add(1,1,0, 0,0,0,  0,0,0,0,             7,1,0,0,32'h22,     0,2,0,0,0);
        // same-cycle rename + commit on x4
        add(1,1,0, 1,4,1,  0,0,0,0,             4,2,0,0,0,          0,2,0,0,0);
        add(1,1,0, 1,4,6,  1,4,1,32'h55,        4,2,0,0,32'h55,     0,2,0,0,0);
        add(1,1,0, 0,0,0,  0,0,0,0,             4,2,1,6,32'h55,     7,1,0,0,32'h22);
        // flush with rdy=0 and a pending rename on x8
        add(1,1,0, 1,1,0,  0,0,0,0,             0,2,0,0,0,          0,2,0,0,0);
        add(1,1,0, 1,2,1,  0,0,0,0,             1,2,1,0,0,          0,2,0,0,0);
        add(1,1,0, 1,3,2,  0,0,0,0,             1,2,1,0,0,          2,2,1,1,0);
        add(1,0,1, 1,8,4,  0,0,0,0,             3,2,1,2,0,          8,2,0,0,0);
        add(1,1,0, 0,0,0,  0,0,0,0,             1,1,0,0,0,          8,1,0,0,0);
        add(1,1,0, 0,0,0,  0,0,0,0,             3,1,0,0,0,          4,1,0,0,32'h55);
        add(1,1,0, 0,0,0,  0,0,0,0,             2,1,0,0,0,          5,1,0,0,32'hDEADBEEF);
        // flush with a concurrent commit still writes the value
        add(1,1,0, 1,9,5,  0,0,0,0,             9,2,0,0,0,          0,2,0,0,0);
        add(1,1,1, 1,10,3, 1,9,5,32'h99,        9,2,0,0,32'h99,     10,2,0,0,0);
        add(1,1,0, 0,0,0,  0,0,0,0,             9,1,0,0,32'h99,     10,1,0,0,0);
        // x0 is immutable
        add(1,1,0, 1,0,5,  1,0,5,32'hFF,        0,2,0,0,0,          0,2,0,0,0);
        add(1,1,0, 0,0,0,  0,0,0,0,             0,2,0,0,0,          0,2,0,0,0);
        // rdy=0: no commit write, no bypass, no rename
        add(1,1,0, 1,12,8, 0,0,0,0,             12,2,0,0,0,         0,2,0,0,0);
        add(1,0,0, 0,0,0,  1,12,8,32'h123,      12,2,1,8,0,         0,2,0,0,0);
        add(1,1,0, 0,0,0,  0,0,0,0,             12,2,1,8,0,         0,2,0,0,0);
        add(1,0,0, 1,13,1, 0,0,0,0,             13,2,0,0,0,         0,2,0,0,0);
        add(1,1,0, 0,0,0,  0,0,0,0,             13,2,0,0,0,         12,2,1,8,0);
        // highest tag value, bypass on both ports
        add(1,1,0, 1,14,15, 0,0,0,0,            14,2,0,0,0,         0,2,0,0,0);
        add(1,1,0, 0,0,0,  1,14,15,32'hF00D,    14,2,0,0,32'hF00D,  14,2,0,0,32'hF00D);
        add(1,1,0, 0,0,0,  0,0,0,0,             14,1,0,0,32'hF00D,  0,2,0,0,0);
        // reset again wipes everything
        add(0,1,0, 1,20,3, 1,5,0,32'h77,        0,0,0,0,0,          0,0,0,0,0);
        add(1,1,0, 0,0,0,  0,0,0,0,             5,2,0,0,0,          7,2,0,0,0);
        add(1,1,0, 0,0,0,  0,0,0,0,             12,2,0,0,0,         20,2,0,0,0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; rdy = vecs[i].rdy; jump_wrong = vecs[i].jw;
            rn_en = vecs[i].rn_en; rn_rd = vecs[i].rn_rd; rn_tag = vecs[i].rn_tag;
            cm_en = vecs[i].cm_en; cm_rd = vecs[i].cm_rd; cm_tag = vecs[i].cm_tag;
            cm_val = vecs[i].cm_val;
            rs1_addr = vecs[i].a1; rs2_addr = vecs[i].a2;
            sb.push_back('{idx: i, port: 1, mode: vecs[i].m1, busy: vecs[i].b1, tag: vecs[i].t1, val: vecs[i].v1});
            sb.push_back('{idx: i, port: 2, mode: vecs[i].m2, busy: vecs[i].b2, tag: vecs[i].t2, val: vecs[i].v2});
            #2;
            e = sb.pop_front();
            check(e, rs1_busy, rs1_tag, rs1_val);
            e = sb.pop_front();
            check(e, rs2_busy, rs2_tag, rs2_val);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
